// File: rtl/alu_seq_control.sv
// rtl/alu_seq_control.sv - ALU control decode plus multi-cycle M-extension sequencer.
// Define ALU_SEQ_MDU_EN to enable the multiply/divide decode and FSM; otherwise f7=0000001 is illegal.
module alu_seq_control #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_flush,
  input  logic [2:0] i_ALUOp,
  input  logic [2:0] i_Funct3,
  input  logic [6:0] i_Funct7,
  output logic [3:0] o_ALUControlLines,
  output logic       o_mdu_start,
  output logic [2:0] o_mdu_op,
  output logic       o_stall,
  output logic       o_done,
  output logic       o_illegal
);

`ifdef ALU_SEQ_MDU_EN
  localparam logic MDU_EN = 1'b1;
`else
  localparam logic MDU_EN = 1'b0;
`endif

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_S1 = 4'd10;
  localparam logic [2:0] OP_MEM = 3'd0, OP_U = 3'd1, OP_S1 = 3'd2, OP_B = 3'd3,
                         OP_I = 3'd4, OP_R = 3'd5;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MDU = 7'b0000001;
  localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] count, count_nxt;
  logic [2:0] mdu_op_q;
  logic [3:0] dec_code;
  logic       dec_ill, dec_mop;
  logic       start, busy, done;

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'd0:    base_op = ALU_ADD;
      3'd1:    base_op = ALU_SLL;
      3'd2:    base_op = ALU_SLT;
      3'd3:    base_op = ALU_SLTU;
      3'd4:    base_op = ALU_XOR;
      3'd5:    base_op = ALU_SRL;
      3'd6:    base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec_code = ALU_ADD;
    dec_ill  = 1'b0;
    dec_mop  = 1'b0;
    case (i_ALUOp)
      OP_MEM, OP_U: dec_code = ALU_ADD;
      OP_S1:        dec_code = ALU_S1;
      OP_B: begin
        case (i_Funct3)
          3'd0, 3'd1: dec_code = ALU_SUB;
          3'd4, 3'd5: dec_code = ALU_SLT;
          3'd6, 3'd7: dec_code = ALU_SLTU;
          default:    dec_ill  = 1'b1;
        endcase
      end
      OP_I: begin
        if (i_Funct3 != 3'd5)        dec_code = base_op(i_Funct3);
        else if (i_Funct7 == F7_BASE) dec_code = ALU_SRL;
        else if (i_Funct7 == F7_ALT)  dec_code = ALU_SRA;
        else                          dec_ill  = 1'b1;
      end
      OP_R: begin
        if (i_Funct7 == F7_BASE)                        dec_code = base_op(i_Funct3);
        else if (i_Funct7 == F7_ALT && i_Funct3 == 3'd0) dec_code = ALU_SUB;
        else if (i_Funct7 == F7_ALT && i_Funct3 == 3'd5) dec_code = ALU_SRA;
        else if (i_Funct7 == F7_MDU && MDU_EN)           dec_mop  = 1'b1;
        else                                             dec_ill  = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    start     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid && dec_mop && !i_flush) begin
          start = 1'b1;
          busy  = 1'b1;
          // Funct3[2] splits MUL class (0..3) from DIV/REM class (4..7)
          if (i_Funct3[2]) begin
            state_nxt = DIV;
            count_nxt = DIV_LOAD;
          end else begin
            state_nxt = MUL;
            count_nxt = MUL_LOAD;
          end
        end
      end
      MUL, DIV: begin
        busy = 1'b1;
        if (count == 8'd0) state_nxt = DONE;
        else               count_nxt = count - 8'd1;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      count    <= 8'd0;
      mdu_op_q <= 3'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (start) mdu_op_q <= i_Funct3;
    end
  end

  assign o_ALUControlLines = (state == IDLE) ? dec_code : ALU_ADD;
  assign o_mdu_start       = start & ~i_rst;
  assign o_stall           = busy & ~i_rst;
  assign o_done            = done & ~i_rst;
  assign o_illegal         = i_valid & dec_ill & ~i_rst;
  assign o_mdu_op          = mdu_op_q;

endmodule

// File: tb/tb_alu_seq_control.sv
// tb/tb_alu_seq_control.sv - scoreboard bench for alu_seq_control against a cycle-count reference model.
module tb_alu_seq_control;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;
`ifdef ALU_SEQ_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                         XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9, S1 = 4'd10;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1, i_valid = 1'b0, i_flush = 1'b0;
  logic [2:0] i_ALUOp = 3'd0, i_Funct3 = 3'd0;
  logic [6:0] i_Funct7 = 7'd0;
  logic [3:0] o_ALUControlLines;
  logic       o_mdu_start, o_stall, o_done, o_illegal;
  logic [2:0] o_mdu_op;

  alu_seq_control #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_ALUOp(i_ALUOp), .i_Funct3(i_Funct3), .i_Funct7(i_Funct7),
    .o_ALUControlLines(o_ALUControlLines), .o_mdu_start(o_mdu_start), .o_mdu_op(o_mdu_op),
    .o_stall(o_stall), .o_done(o_done), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         cyc;
    bit         chk_alu;
    logic [3:0] alu;
    logic       start, stall, done, ill;
    bit         chk_op;
    logic [2:0] op;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;

  // Reference model: an accepted M-op is remembered by its start cycle and latency
  bit         active = 1'b0;
  int         st_cyc = 0, lat = 0;
  logic [2:0] m_op = 3'd0;
  bit         op_known = 1'b0;

  function automatic void decode(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                                 output logic [3:0] code, output bit ill, output bit mop);
    logic [3:0] itab [8];
    itab = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    code = ADD; ill = 1'b0; mop = 1'b0;
    case (aop)
      3'd0, 3'd1: code = ADD;
      3'd2: code = S1;
      3'd3: if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
            else code = (f3 < 3'd2) ? SUB : (f3 < 3'd6) ? SLT : SLTU;
      3'd4: if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
            else code = (f3 == 3'd5 && f7 == 7'h20) ? SRA : itab[f3];
      3'd5: if (f7 == 7'h00) code = itab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) code = SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) code = SRA;
            else if (f7 == 7'h01 && MDU_EN) mop = 1'b1;
            else ill = 1'b1;
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic valid, input logic flush,
                       input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7);
    exp_t       e;
    logic [3:0] code;
    bit         ill, mop, busy, dn, idle, sp;
    @(posedge i_clk);
    #1;
    i_rst = rst; i_valid = valid; i_flush = flush;
    i_ALUOp = aop; i_Funct3 = f3; i_Funct7 = f7;
    cyc++;
    decode(aop, f3, f7, code, ill, mop);
    busy = active && cyc > st_cyc && cyc <= st_cyc + lat;
    dn   = active && cyc == st_cyc + lat + 1;
    idle = !busy && !dn;
    sp   = idle && valid && mop && !flush;
    e.cyc     = cyc;
    e.chk_alu = !rst;
    e.alu     = idle ? code : ADD;
    e.start   = sp && !rst;
    e.stall   = (busy || sp) && !rst;
    e.done    = dn && !rst;
    e.ill     = valid && ill && !rst;
    e.chk_op  = op_known;
    e.op      = m_op;
    sbq.push_back(e);
    if (rst) begin
      active = 1'b0; m_op = 3'd0; op_known = 1'b1;
    end else begin
      if (flush || dn) active = 1'b0;
      if (sp) begin
        active = 1'b1; st_cyc = cyc; m_op = f3;
        lat = f3[2] ? DIV_LAT : MUL_LAT;
      end
    end
  endtask

  task automatic chk(input string name, input int cy, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cy, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.chk_alu) chk("alu_ctrl", e.cyc, int'(o_ALUControlLines), int'(e.alu));
        chk("mdu_start", e.cyc, int'(o_mdu_start), int'(e.start));
        chk("stall", e.cyc, int'(o_stall), int'(e.stall));
        chk("done", e.cyc, int'(o_done), int'(e.done));
        chk("illegal", e.cyc, int'(o_illegal), int'(e.ill));
        if (e.chk_op) chk("mdu_op", e.cyc, int'(o_mdu_op), int'(e.op));
      end
    end
  end

  initial begin
    int r;
    logic [6:0] f7;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 5, 0, 7'h01);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 5, 5, 7'h20);
    drive(0, 1, 0, 5, 1, 7'h20);
    drive(0, 1, 0, 3, 2, 0);
    drive(0, 1, 0, 7, 0, 0);
    drive(0, 1, 0, 4, 5, 7'h20);
    // MUL held across its whole busy window and the DONE cycle
    for (int k = 0; k < 6; k++) drive(0, 1, 0, 5, 0, 7'h01);
    drive(0, 0, 0, 0, 0, 0);
    // DIV flushed at T+10, new MUL at T+11
    drive(0, 1, 0, 5, 4, 7'h01);
    for (int k = 1; k < 10; k++) drive(0, 1, 0, 5, 4, 7'h01);
    drive(0, 1, 1, 5, 4, 7'h01);
    drive(0, 1, 0, 5, 3, 7'h01);
    for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, 0, 0);
    // reset at T+2 during MUL
    drive(0, 1, 0, 5, 2, 7'h01);
    drive(0, 1, 0, 5, 2, 7'h01);
    drive(1, 1, 0, 5, 2, 7'h01);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 5, 1, 7'h01);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 3);
      f7 = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : (r == 2) ? 7'h01 : 7'($urandom);
      drive(($urandom % 150) == 0, ($urandom % 8) != 0, ($urandom % 40) == 0,
            3'($urandom_range(0, 7)), 3'($urandom), f7);
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge i_clk);
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq_control.md
ALU_SEQ_CONTROL -- requirements
Module: alu_seq_control

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, meaning multiply busy cycles (legal range 1..255).
REQ-002 SHALL have parameter DIV_LAT, default 33, meaning divide/remainder busy cycles (legal range 1..255).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have ports i_valid (input, 1, decode holds a valid instruction) and i_flush (input, 1, pipeline flush).
REQ-006 SHALL have ports i_ALUOp (input, 3), i_Funct3 (input, 3) and i_Funct7 (input, 7), the instruction fields.
REQ-007 SHALL have port o_ALUControlLines, output, 4, the ALU operation code taken from the shared ALU defines header.
REQ-008 SHALL have port o_mdu_start, output, 1, a single-cycle start pulse to the multiply/divide unit.
REQ-009 SHALL have port o_mdu_op, output, 3, the latched Funct3 of the M-extension operation.
REQ-010 SHALL have ports o_stall (output, 1, hold decode/issue), o_done (output, 1, M-op result valid) and o_illegal (output, 1, undecodable encoding).

Function
REQ-011 SHALL decode single-cycle ops combinationally, with zero latency:
- MEM/U: ADD; S1: S1.
- B: f3 0/1 to SUB, f3 4/5 to SLT, f3 6/7 to SLTU.
- I: f3 selects ADD/SLL/SLT/SLTU/XOR/SRx/OR/AND; f3=5 uses f7 0000000 for SRL and 0100000 for SRA.
- R: the same table gated by f7; f7 0100000 is legal only for f3=0 (SUB) and f3=5 (SRA).
REQ-012 SHALL, for any encoding not listed (including undefined ALUOp 6/7 and B f3 2/3), drive o_illegal=1 when i_valid=1 and o_ALUControlLines=ADD; outputs SHALL never carry X.
REQ-013 SHALL treat ALUOp=R with f7=0000001 as an M-op, where f3 0..3 selects MUL class and f3 4..7 selects DIV class.
REQ-014 SHALL implement FSM states IDLE, MUL, DIV and DONE, plus an 8-bit down-counter.
REQ-015 SHALL, in IDLE when i_valid=1 and an M-op is decoded (start cycle T):
- assert o_mdu_start=1 and o_stall=1 combinationally;
- latch f3 into o_mdu_op;
- load the counter with LAT-1;
- move to MUL or DIV.
REQ-016 SHALL, in MUL/DIV, hold o_stall=1, decrement the counter each cycle, and at count==0 move to DONE.
REQ-017 SHALL, in DONE, assert o_done=1 and o_stall=0 for exactly one cycle, then return to IDLE; an M-op still present in the DONE cycle SHALL NOT restart the FSM.
REQ-018 SHALL produce o_done at cycle T+LAT+1, with o_stall high from T through T+LAT inclusive.
REQ-019 SHALL, on i_flush=1 in any state, go to IDLE next cycle; an in-progress op SHALL NOT produce o_done, and i_flush in the start cycle SHALL suppress o_mdu_start.
REQ-020 SHALL hold o_mdu_op stable from T+1 until the next start.
REQ-021 SHALL drive o_ALUControlLines=ADD while not in IDLE.
REQ-022 SHALL give i_rst priority over i_flush when both are high.

Reset
REQ-023 SHALL, on i_rst=1, set state IDLE, counter 0 and o_mdu_op 0.
REQ-024 SHALL hold o_mdu_start, o_stall, o_done and o_illegal at 0 during reset.
REQ-025 SHALL abort any in-progress operation on reset, with no o_done.

Configuration
REQ-026 SHALL, with macro ALU_SEQ_MDU_EN defined, implement the M-op decode and FSM as above.
REQ-027 SHALL, without ALU_SEQ_MDU_EN, flag f7=0000001 as illegal, tie o_mdu_start, o_stall, o_done and o_mdu_op to 0, and hold the FSM permanently in IDLE.

Verification
REQ-028 SHALL cover R f3=5 f7=0100000 valid -> o_ALUControlLines=SRA in the same cycle, with o_stall=0 and o_illegal=0.
REQ-029 SHALL cover R f3=1 f7=0100000 valid -> o_illegal=1 and o_ALUControlLines=ADD.
REQ-030 SHALL cover MUL (f3=0, f7=0000001) at T with MUL_LAT=4 -> o_mdu_start pulse at T, o_stall high T..T+4, o_done at T+5 only.
REQ-031 SHALL cover DIV (f3=4) with DIV_LAT=33, i_flush at T+10 -> IDLE at T+11, no o_done, and a new MUL accepted at T+11.
REQ-032 SHALL cover i_rst at T+2 during MUL -> all outputs 0 at T+3 and o_mdu_op=0.
REQ-033 SHALL cover a build without ALU_SEQ_MDU_EN with a valid M-op -> o_illegal=1, o_stall=0 and o_mdu_start=0.
